// File: rtl/piso_frame_ctrl.sv
// Parallel-in/serial-out frame sequencer: accepts a word, shifts it out MSB first, then idles GAP_CYCLES.
// Optional even-parity bit after the LSB when PISO_PARITY_EN is defined.
module piso_frame_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3} state_t;
`endif

    state_t            state;
    state_t            state_next;
    state_t            after_frame;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     bitcnt;
    logic [3:0]        gapcnt;
`ifdef PISO_PARITY_EN
    logic              par_bit;
`endif

    assign after_frame = (GAP_CYCLES > 0) ? GAP : IDLE;

    // NOTE: reset lives inside the clocked block because the reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sout        = shreg[WIDTH-1];
                sout_valid  = 1'b1;
                frame_start = (bitcnt == BIT_LAST);
                if (bitcnt == '0) begin
`ifdef PISO_PARITY_EN
                    state_next = PAR;
`else
                    done       = 1'b1;
                    state_next = after_frame;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                sout       = par_bit;
                sout_valid = 1'b1;
                done       = 1'b1;
                state_next = after_frame;
            end
`endif
            GAP: begin
                if (gapcnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
`ifdef PISO_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                shreg  <= in_data;
                bitcnt <= BIT_LAST;
`ifdef PISO_PARITY_EN
                par_bit <= ^in_data;
`endif
            end else if (state == SHIFT) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                if (bitcnt != '0) begin
                    bitcnt <= bitcnt - CW'(1);
                end
            end

            // Gap counter loads on entry and holds at 0 once the gap has expired.
            if (state_next == GAP && state != GAP) begin
                gapcnt <= GAP_LOAD;
            end else if (state == GAP && gapcnt != '0) begin
                gapcnt <= gapcnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Self-checking bench for piso_frame_ctrl: two instances (GAP_CYCLES=1 and 0) driven by shared
// directed and random stimulus, compared every cycle against a frame-position reference model.
module tb_piso_frame_ctrl;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int GAP0 = 1;
    localparam int GAP1 = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_ready, sout, sout_valid, frame_start, done, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: pos = -1 when idle, else cycle index within the frame (0 = MSB, NBITS.. = gap).
    int               pos  [2];
    logic [WIDTH-1:0] word [2];

    always #5 clk = ~clk;

    piso_frame_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
        .frame_start(frame_start[0]), .done(done[0]), .busy(busy[0])
    );

    piso_frame_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
        .frame_start(frame_start[1]), .done(done[1]), .busy(busy[1])
    );

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP0 : GAP1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pos[d] = -1;
            end else if (pos[d] < 0) begin
                if (in_valid) begin
                    word[d] = in_data;
                    pos[d]  = 0;
                end
            end else begin
                pos[d]++;
                if (pos[d] >= NBITS + gap_of(d)) pos[d] = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_sv, exp_bit;
        for (int d = 0; d < 2; d++) begin
            exp_sv  = (pos[d] >= 0) && (pos[d] < NBITS);
            exp_bit = 1'b0;
            if (exp_sv) begin
                if (pos[d] < WIDTH) exp_bit = word[d][WIDTH-1-pos[d]];
                else                exp_bit = ^word[d];
            end
            check($sformatf("dut%0d in_ready", d),    32'(in_ready[d]),    32'(pos[d] < 0));
            check($sformatf("dut%0d busy", d),        32'(busy[d]),        32'(pos[d] >= 0));
            check($sformatf("dut%0d sout_valid", d),  32'(sout_valid[d]),  32'(exp_sv));
            check($sformatf("dut%0d sout", d),        32'(sout[d]),        32'(exp_bit));
            check($sformatf("dut%0d frame_start", d), 32'(frame_start[d]), 32'(pos[d] == 0));
            check($sformatf("dut%0d done", d),        32'(done[d]),        32'(pos[d] == NBITS - 1));
        end
    endtask

    // Drive inputs, let one posedge happen, then compare on the following negedge.
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] dat);
        rst      = r;
        in_valid = v;
        in_data  = dat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        pos[0] = -1;
        pos[1] = -1;
        word[0] = '0;
        word[1] = '0;

        cycle(1'b1, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);

        cycle(1'b0, 1'b1, 4'b1011);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Held in_valid with data churning while busy; second word offered once idle.
        cycle(1'b0, 1'b1, 4'b1000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'($urandom));
        cycle(1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Reset during a frame.
        cycle(1'b0, 1'b1, 4'b1111);
        cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 4'h0);

        // Continuous in_valid for back-to-back frames.
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 4'($urandom));

        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
